// File: rtl/regwr_arbiter.sv
// Two-requester round-robin arbiter feeding a single register-file write port.
// Optional macro REGWR_ZERO_FILTER_EN suppresses the write strobe for address 0.
`timescale 1ns/1ps
module regwr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              sel,
    output logic              last_grant
);

    typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              sel_q;
    logic              last_grant_q;

    logic              gnt_any;
    logic              gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              gnt_strobe;

    // Grant is combinational so ready can rise in the same cycle as valid.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        if (!rst && !wr_stall) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_idx = ~last_grant_q;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b0;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b1;
            end
        end
        gnt_addr = gnt_idx ? req1_addr : req0_addr;
        gnt_data = gnt_idx ? req1_data : req0_data;
`ifdef REGWR_ZERO_FILTER_EN
        gnt_strobe = (gnt_addr != '0);
`else
        gnt_strobe = 1'b1;
`endif
    end

    assign req0_ready = gnt_any && !gnt_idx;
    assign req1_ready = gnt_any &&  gnt_idx;

    // A stalled write port freezes every register, including the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (!wr_stall) begin
            if (gnt_any) begin
                last_grant_q <= gnt_idx;
                sel_q        <= gnt_idx;
                wr_addr_q    <= gnt_addr;
                wr_data_q    <= gnt_data;
                state_q      <= gnt_strobe ? S_WRITE : S_IDLE;
            end else begin
                state_q      <= S_IDLE;
            end
        end
    end

    assign wr_en      = (state_q == S_WRITE);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign sel        = sel_q;
    assign last_grant = last_grant_q;

endmodule
